// File: rtl/dot_product_accumulator_if.sv
// Product-in and result-out channels of the dot-product accumulator.
// Both channels use valid/ready: a beat transfers on a rising clk edge
// where valid && ready. Once valid is high, the source holds the payload
// stable until that transfer happens. The sink may change ready freely.
interface dot_product_accumulator_if #(
  parameter int PROD_W = 64
);
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              res_valid;
  logic              res_ready;
  logic [PROD_W-1:0] res_data;
  logic              res_overflow;

  // Producer of products and consumer of results (the surrounding system).
  modport master (
    output prod_valid, prod_data, res_ready,
    input  prod_ready, res_valid, res_data, res_overflow
  );

  // The accumulator itself.
  modport slave (
    input  prod_valid, prod_data, res_ready,
    output prod_ready, res_valid, res_data, res_overflow
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums a programmed number of signed products in a guarded accumulator.
// It then returns one saturated result through the result channel.
module dot_product_accumulator #(
  parameter int PROD_W  = 64,
  parameter int GUARD_W = 8,
  parameter int LEN_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  dot_product_accumulator_if.slave bus,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  localparam int ACC_W = PROD_W + GUARD_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [PROD_W-1:0] SAT_MAX = {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic [PROD_W-1:0] SAT_MIN = {1'b1, {(PROD_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] res_data_q, res_data_d;
  logic              res_ovf_q, res_ovf_d;

  logic              xfer;
  logic [ACC_W-1:0]  sum;
  logic [GUARD_W:0]  sum_top;
  logic              sum_ovf;
  logic [PROD_W-1:0] sum_sat;

  // Product channel handshake. Final sum and clamp are taken on the extended sum.
  always_comb begin
    xfer    = bus.prod_valid && (state_q == ST_ACC);
    sum     = acc_q + {{GUARD_W{bus.prod_data[PROD_W-1]}}, bus.prod_data};
    sum_top = sum[ACC_W-1:PROD_W-1];
    // The sum fits in PROD_W bits only if the guard bits and the result
    // sign bit all agree.
    sum_ovf = !((&sum_top) || !(|sum_top));
    if (sum_ovf) sum_sat = sum[ACC_W-1] ? SAT_MIN : SAT_MAX;
    else         sum_sat = sum[PROD_W-1:0];
  end

  // Next-state logic for the IDLE -> ACC -> HOLD job sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            acc_d   = '0;
            cnt_d   = len;
            state_d = ST_ACC;
          end else begin
            res_data_d = '0;
            res_ovf_d  = 1'b0;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_ACC: begin
        if (xfer) begin
          acc_d = sum;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            res_data_d = sum_sat;
            res_ovf_d  = sum_ovf;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. Reset aborts any job in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  // Outputs decode straight from registered state, so ready never depends on valid.
  always_comb begin
    bus.prod_ready   = (state_q == ST_ACC);
    bus.res_valid    = (state_q == ST_HOLD);
    bus.res_data     = res_data_q;
    bus.res_overflow = res_ovf_q;
    busy             = (state_q != ST_IDLE);
    dbg_state        = state_q;
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: directed corner jobs plus random jobs,
// with a queue scoreboard fed by a high-level arithmetic model.
module tb_dot_product_accumulator;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic [1:0] dbg_state;

  dot_product_accumulator_if #(.PROD_W(64)) bus_if ();

  dot_product_accumulator #(.PROD_W(64), .GUARD_W(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .bus       (bus_if.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  localparam logic [63:0] P_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P_MIN = 64'h8000_0000_0000_0000;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          accepted = 0;
  logic [63:0] prod_q[$];
  logic [64:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact integer sum of the products. The result clamps to the signed 64-bit range.
  function automatic logic [64:0] model(input int n);
    logic signed [79:0] s;
    logic signed [63:0] t;
    logic signed [79:0] hi;
    logic signed [79:0] lo;
    s  = '0;
    hi = 80'sh7FFF_FFFF_FFFF_FFFF;
    lo = -hi - 80'sd1;
    for (int i = 0; i < n; i++) begin
      t = prod_q[i];
      s = s + t;
    end
    if (s > hi)      return {1'b1, P_MAX};
    else if (s < lo) return {1'b1, P_MIN};
    else             return {1'b0, s[63:0]};
  endfunction

  function automatic logic [63:0] rand_prod();
    logic signed [63:0] v;
    case ($urandom_range(0, 3))
      0: begin v = 64'($urandom_range(0, 2000)); v = v - 64'sd1000; end
      1: v = P_MAX;
      2: v = P_MIN;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus_if.prod_valid && bus_if.prod_ready) accepted++;
    if (rst_n && bus_if.res_valid) begin
      check("prod_ready_in_hold", {64'd0, bus_if.prod_ready}, 65'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_result", {bus_if.res_overflow, bus_if.res_data}, 65'h1_DEAD_BEEF_DEAD_BEEF);
      end else begin
        check("result", {bus_if.res_overflow, bus_if.res_data}, exp_q[0]);
        if (bus_if.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one job over the products in prod_q.
  task automatic do_job(input int n, input bit gaps, input int hold_lo, input bit poke);
    int idx;
    int budget;
    bit v;
    bit xfer;
    idx = 0;
    budget = 0;
    exp_q.push_back(model(n));
    accepted = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = n[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < n && budget < 2000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.prod_valid = v;
      bus_if.prod_data  = prod_q[idx];
      start = poke && (idx == 1);
      len   = 8'd3;
      @(negedge clk);
      xfer = v && bus_if.prod_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      budget++;
    end
    start = 1'b0;
    check("prod_transfers_done", 65'(idx), 65'(n));
    // During a len=0 job, valid stays high to show nothing is taken.
    bus_if.prod_valid = (n == 0);
    bus_if.prod_data  = 64'd5;
    bus_if.res_ready  = 1'b0;
    @(negedge clk);
    check("res_valid_latency", {64'd0, bus_if.res_valid}, 65'd1);
    repeat (hold_lo) begin
      @(posedge clk); #1;
      start = poke;
      len   = 8'd7;
    end
    @(posedge clk); #1;
    start = 1'b0;
    bus_if.res_ready = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus_if.res_valid && budget < 100);
    if (!bus_if.res_valid) check("res_valid_timeout", 65'd0, 65'd1);
    @(posedge clk); #1;
    bus_if.res_ready  = 1'b0;
    bus_if.prod_valid = 1'b0;
    @(negedge clk);
    check("busy_after_accept", {64'd0, busy}, 65'd0);
    check("res_valid_after_accept", {64'd0, bus_if.res_valid}, 65'd0);
    check("products_accepted", 65'(accepted), 65'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    bus_if.prod_valid = 1'b0;
    bus_if.prod_data  = '0;
    bus_if.res_ready  = 1'b0;
    #12;
    check("rst_busy", {64'd0, busy}, 65'd0);
    check("rst_res_valid", {64'd0, bus_if.res_valid}, 65'd0);
    check("rst_prod_ready", {64'd0, bus_if.prod_ready}, 65'd0);
    check("rst_res", {bus_if.res_overflow, bus_if.res_data}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sum: 6 - 10 + 100 = 96
    prod_q = '{64'd6, 64'hFFFF_FFFF_FFFF_FFF6, 64'd100};
    check("model_basic", model(3), {1'b0, 64'd96});
    do_job(3, 1'b0, 0, 1'b0);

    // Positive saturation
    prod_q = '{P_MAX, P_MAX};
    do_job(2, 1'b0, 0, 1'b0);
    // Reaches exactly the minimum without clamping
    prod_q = '{P_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    do_job(3, 1'b0, 0, 1'b0);
    // Negative saturation
    prod_q = '{P_MIN, P_MIN};
    do_job(2, 1'b0, 1, 1'b0);

    // Handshake stress: gaps, result held off, stray start pulses
    prod_q = '{64'd11, 64'hFFFF_FFFF_FFFF_FF00, 64'd1000, 64'd7};
    do_job(4, 1'b1, 5, 1'b1);

    // len = 0
    prod_q.delete();
    do_job(0, 1'b0, 2, 1'b0);

    // Reset in the middle of a job after two transfers
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    bus_if.prod_valid = 1'b1;
    bus_if.prod_data  = 64'd1000;
    @(posedge clk); #1;
    bus_if.prod_data  = 64'd2000;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {64'd0, busy}, 65'd0);
    check("midrst_prod_ready", {64'd0, bus_if.prod_ready}, 65'd0);
    check("midrst_res_valid", {64'd0, bus_if.res_valid}, 65'd0);
    check("midrst_res", {bus_if.res_overflow, bus_if.res_data}, 65'd0);
    bus_if.prod_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prod_q = '{64'd42};
    do_job(1, 1'b0, 0, 1'b0);

    // Maximum length, full-scale positive terms
    prod_q.delete();
    for (int i = 0; i < 255; i++) prod_q.push_back(P_MAX);
    do_job(255, 1'b0, 0, 1'b0);

    // Random jobs
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(1, 12);
      prod_q.delete();
      for (int i = 0; i < n; i++) prod_q.push_back(rand_prod());
      do_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 65'(exp_q.size()), 65'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
